sequence_checker: RTL and testbench

SEQUENCE_CHECKER -- requirements
Module: sequence_checker

---
 rtl/sequence_checker.sv | 147 ++++++++++++++
 tb/tb_sequence_checker.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_checker.sv
// Memory-game round checker: debounces active-low buttons, captures one press per step,
// and scores the captured presses against a latched pattern.
module sequence_checker #(
  parameter int unsigned WIDTH        = 3,
  parameter int unsigned STEPS        = 4,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned TIMEOUT_CYC  = 50000000
) (
  input  logic                         osc_clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [STEPS*(WIDTH+1)-1:0]   pattern,
  input  logic [WIDTH:0]               button,
  output logic [WIDTH:0]               led,
  output logic [STEPS*(WIDTH+1)-1:0]   user_entry,
  output logic [3:0]                   correct_count,
  output logic                         busy,
  output logic                         done,
  output logic                         pass
);
  localparam int unsigned N  = WIDTH + 1;
  localparam int unsigned PW = STEPS * N;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [N-1:0] Ones = '1;

  typedef enum logic [2:0] {StIdle, StWaitRelease, StWaitPress, StCheck, StDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    sync1_q, sync2_q, prev_q, led_q;
  logic [DW-1:0]   stable_q, stable_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [SW-1:0]   step_q;
  logic [PW-1:0]   pattern_q, user_entry_q;
  logic [3:0]      count_q, count_inc;
  logic            pass_q;

  logic none, same_cand, release_ok, accept, timeout, last_step, match;

  assign none       = (sync2_q == Ones);
  assign release_ok = none && (stable_q == DW'(DEBOUNCE_CYC - 1));
  // A run continues only while the same non-idle value repeats on consecutive cycles.
  assign same_cand  = !none && (sync2_q == prev_q) && (stable_q != '0);
  assign accept     = !none && (same_cand ? (stable_q == DW'(DEBOUNCE_CYC - 1))
                                          : (DEBOUNCE_CYC == 1));
  assign timeout    = none && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign last_step  = (step_q == SW'(STEPS - 1));
  assign match      = (user_entry_q[step_q*N +: N] == pattern_q[step_q*N +: N]);
  assign count_inc  = count_q + {3'b000, match};

  always_ff @(posedge osc_clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:        if (start) state_d = StWaitRelease;
      StWaitRelease: if (release_ok) state_d = StWaitPress;
      StWaitPress:   if (accept || timeout) state_d = StCheck;
      StCheck:       state_d = last_step ? StDone : StWaitRelease;
      StDone:        state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StWaitRelease) || (state_q == StWaitPress) || (state_q == StCheck);
    done = (state_q == StDone);
  end

  // Timeout only advances while nothing is pressed, so a stabilizing candidate pauses it.
  always_comb begin
    stable_d = '0;
    tmo_d    = '0;
    unique case (state_q)
      StWaitRelease: stable_d = (none && !release_ok) ? stable_q + DW'(1) : '0;
      StWaitPress: begin
        if (none) begin
          tmo_d = tmo_q + TW'(1);
        end else begin
          tmo_d    = tmo_q;
          stable_d = same_cand ? stable_q + DW'(1) : DW'(1);
        end
        if (accept || timeout) begin
          stable_d = '0;
          tmo_d    = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge osc_clk) begin
    if (reset) begin
      sync1_q      <= Ones;
      sync2_q      <= Ones;
      prev_q       <= Ones;
      stable_q     <= '0;
      tmo_q        <= '0;
      step_q       <= '0;
      pattern_q    <= '1;
      user_entry_q <= '1;
      led_q        <= Ones;
      count_q      <= '0;
      pass_q       <= 1'b0;
    end else begin
      sync1_q  <= button;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      stable_q <= stable_d;
      tmo_q    <= tmo_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pattern_q    <= pattern;
            user_entry_q <= '1;
            count_q      <= '0;
            step_q       <= '0;
            pass_q       <= 1'b0;
          end
        end
        StWaitRelease: if (release_ok) led_q <= Ones;
        StWaitPress: begin
          if (accept) begin
            user_entry_q[step_q*N +: N] <= sync2_q;
            led_q                       <= sync2_q;
          end
        end
        StCheck: begin
          count_q <= count_inc;
          if (last_step) pass_q <= (count_inc == 4'(STEPS));
          else           step_q <= step_q + SW'(1);
        end
        StDone:  led_q <= Ones;
        default: ;
      endcase
    end
  end

  assign led           = led_q;
  assign user_entry    = user_entry_q;
  assign correct_count = count_q;
  assign pass          = pass_q;
endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: directed scenarios plus random stimulus, checked every cycle
// against a procedural round model.
module tb_sequence_checker;
  localparam int unsigned WIDTH = 3;
  localparam int unsigned STEPS = 4;
  localparam int unsigned DEB   = 4;
  localparam int unsigned TMO   = 100;
  localparam int unsigned N     = WIDTH + 1;
  localparam int unsigned PW    = STEPS * N;
  localparam logic [N-1:0] ONES = '1;

  logic          osc_clk = 1'b0;
  logic          reset   = 1'b1;
  logic          start   = 1'b0;
  logic [PW-1:0] pattern = '1;
  logic [N-1:0]  button  = '1;
  logic [N-1:0]  led;
  logic [PW-1:0] user_entry;
  logic [3:0]    correct_count;
  logic          busy, done, pass;

  sequence_checker #(
    .WIDTH(WIDTH), .STEPS(STEPS), .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TMO)
  ) dut (
    .osc_clk(osc_clk), .reset(reset), .start(start), .pattern(pattern), .button(button),
    .led(led), .user_entry(user_entry), .correct_count(correct_count),
    .busy(busy), .done(done), .pass(pass)
  );

  always #5 osc_clk = ~osc_clk;

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0]  ms1, ms2, sb, e_led;
  logic [PW-1:0] e_entry, m_pat;
  int            e_cnt;
  bit            e_pass, e_busy, e_done, abort, model_valid;

  // One clock edge as seen by the round: sb is the 2-cycle-delayed button.
  task automatic step_edge();
    @(posedge osc_clk);
    sb     = ms2;
    ms2    = ms1;
    ms1    = button;
    e_done = 1'b0;
    if (reset) begin
      ms1 = ONES; ms2 = ONES; e_led = ONES; e_entry = '1;
      e_cnt = 0; e_pass = 1'b0; e_busy = 1'b0; abort = 1'b1; model_valid = 1'b1;
    end
  endtask

  task automatic model_round();
    int run, t;
    logic [N-1:0] prev, slot;
    for (int s = 0; s < STEPS; s++) begin
      run = 0;
      while (run < DEB) begin
        step_edge();
        if (abort) return;
        run = (sb == ONES) ? run + 1 : 0;
      end
      e_led = ONES;
      run = 0; t = 0; prev = ONES; slot = ONES;
      forever begin
        step_edge();
        if (abort) return;
        if (sb != ONES) begin
          run = (sb == prev && run > 0) ? run + 1 : 1;
          if (run == DEB) begin
            slot  = sb;
            e_led = sb;
            break;
          end
        end else begin
          run = 0;
          t++;
          if (t == TMO) break;
        end
        prev = sb;
      end
      e_entry[s*N +: N] = slot;
      step_edge();
      if (abort) return;
      if (slot == m_pat[s*N +: N]) e_cnt++;
      if (s == STEPS - 1) begin
        e_pass = (e_cnt == STEPS);
        e_busy = 1'b0;
        e_done = 1'b1;
      end
    end
    step_edge();
    if (abort) return;
    e_led = ONES;
  endtask

  initial begin
    ms1 = ONES; ms2 = ONES; sb = ONES; e_led = ONES; e_entry = '1; m_pat = '1;
    e_cnt = 0; e_pass = 0; e_busy = 0; e_done = 0; abort = 0; model_valid = 0;
    forever begin
      step_edge();
      if (!abort && start) begin
        m_pat = pattern; e_entry = '1; e_cnt = 0; e_pass = 1'b0; e_busy = 1'b1;
        model_round();
      end
      abort = 1'b0;
    end
  end

  always @(negedge osc_clk) begin
    if (model_valid) begin
      cmp("led", 32'(led), 32'(e_led));
      cmp("user_entry", 32'(user_entry), 32'(e_entry));
      cmp("correct_count", 32'(correct_count), 32'(e_cnt));
      cmp("busy", 32'(busy), 32'(e_busy));
      cmp("done", 32'(done), 32'(e_done));
      cmp("pass", 32'(pass), 32'(e_pass));
    end
  end

  // ---------------- done capture ----------------
  int            done_cnt = 0;
  logic [PW-1:0] snap_entry;
  logic [3:0]    snap_cnt;
  logic          snap_pass;

  always @(negedge osc_clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      snap_entry = user_entry;
      snap_cnt   = correct_count;
      snap_pass  = pass;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge osc_clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
  endtask

  task automatic press(input logic [N-1:0] v, input int hold, input int rel);
    button = v;
    wait_cyc(hold);
    button = ONES;
    wait_cyc(rel);
  endtask

  task automatic wait_done(input int base, input int budget, input string name, output int k);
    k = 0;
    while (done_cnt == base && k < budget) begin
      wait_cyc(1);
      k++;
    end
    if (done_cnt == base) begin
      total++;
      bad++;
      $display("FAIL %s: no done pulse within %0d cycles", name, budget);
    end
  endtask

  task automatic run_steps(input logic [PW-1:0] presses);
    for (int s = 0; s < STEPS; s++) press(presses[s*N +: N], 10, 10);
  endtask

  localparam logic [PW-1:0] PAT0 = 16'hE7BD;

  initial begin
    int base, k;
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(1);
    cmp("reset_busy", 32'(busy), 32'd0);
    cmp("reset_led", 32'(led), 32'hF);
    cmp("reset_entry", 32'(user_entry), 32'hFFFF);
    cmp("reset_count", 32'(correct_count), 32'd0);

    // All steps correct.
    pattern = PAT0;
    base = done_cnt;
    pulse_start();
    wait_cyc(8);
    run_steps(16'hE7BD);
    wait_done(base, 50, "r030_done", k);
    cmp("r030_entry", 32'(snap_entry), 32'hE7BD);
    cmp("r030_count", 32'(snap_cnt), 32'd4);
    cmp("r030_pass", 32'(snap_pass), 32'd1);
    cmp("r030_model_entry", 32'(e_entry), 32'hE7BD);

    // Step 2 wrong.
    base = done_cnt;
    pulse_start();
    wait_cyc(8);
    run_steps(16'hEEBD);
    wait_done(base, 50, "r031_done", k);
    cmp("r031_entry", 32'(snap_entry), 32'hEEBD);
    cmp("r031_count", 32'(snap_cnt), 32'd3);
    cmp("r031_pass", 32'(snap_pass), 32'd0);
    cmp("r031_model_count", 32'(e_cnt), 32'd3);

    // Every step times out.
    base = done_cnt;
    pulse_start();
    wait_done(base, 600, "r032_done", k);
    cmp("r032_entry", 32'(snap_entry), 32'hFFFF);
    cmp("r032_count", 32'(snap_cnt), 32'd0);
    cmp("r032_latency", 32'(k >= 410 && k <= 440), 32'd1);
    wait_cyc(4);

    // Bouncing step-0 press, then a clean hold.
    base = done_cnt;
    pulse_start();
    wait_cyc(8);
    for (int i = 0; i < 4; i++) begin
      button = 4'b1101; wait_cyc(2);
      button = ONES;    wait_cyc(2);
    end
    cmp("r033_no_accept", 32'(user_entry), 32'hFFFF);
    button = 4'b1101;
    wait_cyc(8);
    cmp("r033_led", 32'(led), 32'hD);
    wait_cyc(2);
    button = ONES;
    wait_cyc(1);
    cmp("r033_led_held", 32'(led), 32'hD);
    wait_cyc(9);
    for (int s = 1; s < STEPS; s++) press(PAT0[s*N +: N], 10, 10);
    wait_done(base, 50, "r033_done", k);
    cmp("r033_entry", 32'(snap_entry), 32'hE7BD);
    cmp("r033_count", 32'(snap_cnt), 32'd4);

    // Button held through start; second start mid-round.
    base = done_cnt;
    button = 4'b1110;
    wait_cyc(2);
    pulse_start();
    wait_cyc(10);
    cmp("r034_no_accept", 32'(user_entry), 32'hFFFF);
    cmp("r034_busy", 32'(busy), 32'd1);
    button = ONES;
    wait_cyc(8);
    press(4'b1101, 10, 10);
    press(4'b1011, 10, 10);
    pulse_start();
    cmp("r034_restart_ignored", 32'(user_entry), 32'hFFBD);
    press(4'b0111, 10, 10);
    press(4'b1110, 10, 10);
    wait_done(base, 50, "r034_done", k);
    cmp("r034_entry", 32'(snap_entry), 32'hE7BD);
    cmp("r034_count", 32'(snap_cnt), 32'd4);

    // Reset during step 2, then a clean round.
    pulse_start();
    wait_cyc(8);
    press(4'b1101, 10, 10);
    press(4'b1011, 10, 10);
    button = 4'b0111;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    button = ONES;
    cmp("r035_busy", 32'(busy), 32'd0);
    cmp("r035_count", 32'(correct_count), 32'd0);
    cmp("r035_led", 32'(led), 32'hF);
    wait_cyc(3);
    base = done_cnt;
    pulse_start();
    wait_cyc(8);
    run_steps(16'hE7BD);
    wait_done(base, 50, "r035_done", k);
    cmp("r035_entry", 32'(snap_entry), 32'hE7BD);
    cmp("r035_pass", 32'(snap_pass), 32'd1);

    // Random stimulus, checked cycle by cycle against the model.
    for (int i = 0; i < 300; i++) begin
      int r, hold;
      r = $urandom_range(0, 9);
      for (int s = 0; s < STEPS; s++) pattern[s*N +: N] = ~(N'(1) << $urandom_range(0, N - 1));
      if (r < 3)      button = ONES;
      else if (r < 8) button = ~(N'(1) << $urandom_range(0, N - 1));
      else            button = N'($urandom);
      hold  = (r == 0) ? $urandom_range(20, 110) : $urandom_range(1, 12);
      start = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 60) == 0);
      wait_cyc(1);
      start = 1'b0;
      reset = 1'b0;
      if (hold > 1) wait_cyc(hold - 1);
    end
    button = ONES;
    wait_cyc(700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
